// File: rtl/cabac_rate_pkg.sv
// Shared definitions for the CABAC rate-estimation blocks.
//   C1FLAG_NUMBER_DEF : default count of coefficients that get a greater1 context
//   C2FLAG_NUMBER_DEF : default greater2 flag budget per coefficient group
//   seq_state_e       : state encoding of the level sequencer FSM
package cabac_rate_pkg;

    localparam int C1FLAG_NUMBER_DEF = 4;
    localparam int C2FLAG_NUMBER_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_CALC   = 2'd2,
        ST_EMIT   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/base_level_calc.sv
// Base level calculator: one-cycle registered lookup of the base level
// for a coefficient from its c1Idx / c2Idx.
//   clk, rst         : clock, synchronous active-high reset
//   start            : sample c1_idx/c2_idx this cycle
//   c1_idx, c2_idx   : running greater1 / greater2 indices
//   done             : result valid, exactly one cycle after start
//   base_level       : 3, 2 or 1
module base_level_calc
    import cabac_rate_pkg::*;
#(
    parameter int C1FLAG_NUMBER = C1FLAG_NUMBER_DEF,
    parameter int C2FLAG_NUMBER = C2FLAG_NUMBER_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] c1_idx,
    input  logic [7:0] c2_idx,
    output logic       done,
    output logic [7:0] base_level
);

    // Compare in 9 bits so a limit of 256 still works against an 8-bit index.
    localparam logic [8:0] C1_LIM = 9'(C1FLAG_NUMBER);
    localparam logic [8:0] C2_LIM = 9'(C2FLAG_NUMBER);

    logic       c1_below;
    logic       c2_below;
    logic [7:0] base_d;
    logic [7:0] base_q;
    logic       done_q;

    assign c1_below = ({1'b0, c1_idx} < C1_LIM);
    assign c2_below = ({1'b0, c2_idx} < C2_LIM);

    always_comb begin
        base_d = 8'd1;
        if (c1_below && c2_below) begin
            base_d = 8'd3;
        end else if (c1_below) begin
            base_d = 8'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            base_q <= 8'd0;
        end else begin
            done_q <= start;
            if (start) begin
                base_q <= base_d;
            end
        end
    end

    assign done       = done_q;
    assign base_level = base_q;

endmodule

// File: rtl/cg_level_sequencer.sv
// Coefficient-group level sequencer. Accepts absolute levels of one CG in
// reverse scan order, tracks c1Idx/c2Idx, obtains the base level from
// base_level_calc and emits base level, escape flag and remainder.
//   clk, rst           : clock, synchronous active-high reset
//   cg_start           : opens a new CG (honoured only when idle)
//   in_valid/in_ready  : input handshake; in_abs_level, in_last
//   out_valid/out_ready: output handshake; out_abs_level, out_c1_idx,
//                        out_c2_idx, out_base_level, out_escape, out_rem, out_last
//   cg_done            : one-cycle pulse when the CG completes
//   busy               : FSM not idle
module cg_level_sequencer
    import cabac_rate_pkg::*;
#(
    parameter int C1FLAG_NUMBER = C1FLAG_NUMBER_DEF,
    parameter int C2FLAG_NUMBER = C2FLAG_NUMBER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cg_start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_abs_level,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_abs_level,
    output logic [7:0]  out_c1_idx,
    output logic [7:0]  out_c2_idx,
    output logic [7:0]  out_base_level,
    output logic        out_escape,
    output logic [15:0] out_rem,
    output logic        out_last,
    output logic        cg_done,
    output logic        busy
);

    localparam logic [8:0] C1_LIM = 9'(C1FLAG_NUMBER);

    seq_state_e  state_q, state_d;
    logic [7:0]  c1_q, c1_d;
    logic [7:0]  c2_q, c2_d;
    logic [15:0] lvl_q, lvl_d;
    logic        last_q, last_d;
    logic        start_q, start_d;
    logic        cg_done_q, cg_done_d;
    logic [15:0] oabs_q, oabs_d;
    logic [7:0]  oc1_q, oc1_d;
    logic [7:0]  oc2_q, oc2_d;
    logic [7:0]  obase_q, obase_d;
    logic        oesc_q, oesc_d;
    logic [15:0] orem_q, orem_d;
    logic        olast_q, olast_d;

    logic        calc_done;
    logic [7:0]  calc_base;
    logic [15:0] base_ext;
    logic        escape;

    base_level_calc #(
        .C1FLAG_NUMBER(C1FLAG_NUMBER),
        .C2FLAG_NUMBER(C2FLAG_NUMBER)
    ) u_base_level_calc (
        .clk       (clk),
        .rst       (rst),
        .start     (start_q),
        .c1_idx    (c1_q),
        .c2_idx    (c2_q),
        .done      (calc_done),
        .base_level(calc_base)
    );

    assign base_ext = {8'd0, calc_base};
    assign escape   = (lvl_q >= base_ext);

    always_comb begin
        state_d   = state_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        lvl_d     = lvl_q;
        last_d    = last_q;
        start_d   = 1'b0;
        cg_done_d = 1'b0;
        oabs_d    = oabs_q;
        oc1_d     = oc1_q;
        oc2_d     = oc2_q;
        obase_d   = obase_q;
        oesc_d    = oesc_q;
        orem_d    = orem_q;
        olast_d   = olast_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cg_start) begin
                    state_d = ST_ACCEPT;
                    c1_d    = 8'd0;
                    c2_d    = 8'd0;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    if (in_abs_level != 16'd0) begin
                        lvl_d   = in_abs_level;
                        last_d  = in_last;
                        start_d = 1'b1;
                        state_d = ST_CALC;
                    end else if (in_last) begin
                        // Zero level closing the CG: nothing to emit.
                        cg_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_CALC: begin
                if (calc_done) begin
                    oabs_d  = lvl_q;
                    oc1_d   = c1_q;
                    oc2_d   = c2_q;
                    obase_d = calc_base;
                    oesc_d  = escape;
                    orem_d  = escape ? (lvl_q - base_ext) : 16'd0;
                    olast_d = last_q;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (c1_q != 8'hFF) begin
                        c1_d = c1_q + 8'd1;
                    end
                    // greater2 budget only consumed by coefficients that still
                    // carried a greater1 context.
                    if ((oabs_q > 16'd1) && ({1'b0, c1_q} < C1_LIM) && (c2_q != 8'hFF)) begin
                        c2_d = c2_q + 8'd1;
                    end
                    if (olast_q) begin
                        cg_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            c1_q      <= 8'd0;
            c2_q      <= 8'd0;
            lvl_q     <= 16'd0;
            last_q    <= 1'b0;
            start_q   <= 1'b0;
            cg_done_q <= 1'b0;
            oabs_q    <= 16'd0;
            oc1_q     <= 8'd0;
            oc2_q     <= 8'd0;
            obase_q   <= 8'd0;
            oesc_q    <= 1'b0;
            orem_q    <= 16'd0;
            olast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            lvl_q     <= lvl_d;
            last_q    <= last_d;
            start_q   <= start_d;
            cg_done_q <= cg_done_d;
            oabs_q    <= oabs_d;
            oc1_q     <= oc1_d;
            oc2_q     <= oc2_d;
            obase_q   <= obase_d;
            oesc_q    <= oesc_d;
            orem_q    <= orem_d;
            olast_q   <= olast_d;
        end
    end

    assign in_ready       = (state_q == ST_ACCEPT);
    assign out_valid      = (state_q == ST_EMIT);
    assign busy           = (state_q != ST_IDLE);
    assign cg_done        = cg_done_q;
    assign out_abs_level  = oabs_q;
    assign out_c1_idx     = oc1_q;
    assign out_c2_idx     = oc2_q;
    assign out_base_level = obase_q;
    assign out_escape     = oesc_q;
    assign out_rem        = orem_q;
    assign out_last       = olast_q;

endmodule

// File: tb/tb_cg_level_sequencer.sv
// Directed self-checking bench for cg_level_sequencer.
module tb_cg_level_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cg_start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_abs_level;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_abs_level;
    logic [7:0]  out_c1_idx;
    logic [7:0]  out_c2_idx;
    logic [7:0]  out_base_level;
    logic        out_escape;
    logic [15:0] out_rem;
    logic        out_last;
    logic        cg_done;
    logic        busy;

    int asserts  = 0;
    int failures = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;

    always #5 clk = ~clk;

    cg_level_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cg_start      (cg_start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_abs_level  (in_abs_level),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_abs_level (out_abs_level),
        .out_c1_idx    (out_c1_idx),
        .out_c2_idx    (out_c2_idx),
        .out_base_level(out_base_level),
        .out_escape    (out_escape),
        .out_rem       (out_rem),
        .out_last      (out_last),
        .cg_done       (cg_done),
        .busy          (busy)
    );

    always @(negedge clk) begin
        if (cg_done) done_cnt++;
    end

    // ---------------- stimulus primitives (no checking inside) ----------------
    task automatic start_cg();
        @(negedge clk);
        cg_start = 1'b1;
        @(negedge clk);
        cg_start = 1'b0;
    endtask

    // Present one level; returns at the negedge after the handshake edge.
    task automatic send_in(input logic [15:0] lvl, input logic last, output logic ok);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_abs_level = lvl;
        in_last = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Wait (bounded) for out_valid; waits = negedges spent waiting.
    task automatic wait_out(output logic ok, output int waits);
        waits = 0;
        while (!out_valid && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        ok = out_valid;
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        if (out_valid) xfer_cnt++;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        asserts++;
        if ({out_valid, in_ready, cg_done, busy, out_escape, out_last} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {out_valid, in_ready, cg_done, busy, out_escape, out_last});
        end
        asserts++;
        if ({out_abs_level, out_c1_idx, out_c2_idx, out_base_level, out_rem} !== 56'd0) begin
            failures++;
            $display("FAIL reset_data: got abs=%0d c1=%0d c2=%0d base=%0d rem=%0d expected all 0",
                     out_abs_level, out_c1_idx, out_c2_idx, out_base_level, out_rem);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic run_seq(input string name, input int n,
                           input int lv[6], input int eb[6], input int ec2[6],
                           input int ee[6], input int er[6]);
        logic ok;
        int   waits;
        int   d0;
        d0 = done_cnt;
        start_cg();
        for (int i = 0; i < n; i++) begin
            send_in(16'(lv[i]), (i == n - 1), ok);
            wait_out(ok, waits);
            asserts++;
            if (!ok) begin
                failures++;
                $display("FAIL %s_timeout[%0d]: out_valid never rose", name, i);
            end
            asserts++;
            if (out_base_level !== 8'(eb[i]) || out_c1_idx !== 8'(i) || out_c2_idx !== 8'(ec2[i])) begin
                failures++;
                $display("FAIL %s_idx[%0d]: got base=%0d c1=%0d c2=%0d expected base=%0d c1=%0d c2=%0d",
                         name, i, out_base_level, out_c1_idx, out_c2_idx, eb[i], i, ec2[i]);
            end
            asserts++;
            if (out_escape !== ee[i][0] || out_rem !== 16'(er[i]) || out_abs_level !== 16'(lv[i])
                || out_last !== (i == n - 1)) begin
                failures++;
                $display("FAIL %s_data[%0d]: got esc=%0b rem=%0d abs=%0d last=%0b expected esc=%0d rem=%0d abs=%0d last=%0b",
                         name, i, out_escape, out_rem, out_abs_level, out_last, ee[i], er[i], lv[i], (i == n - 1));
            end
            $display("%s coef %0d: lvl=%0d base=%0d c1=%0d c2=%0d esc=%0b rem=%0d",
                     name, i, out_abs_level, out_base_level, out_c1_idx, out_c2_idx, out_escape, out_rem);
            accept_out();
        end
        repeat (2) @(negedge clk);
        asserts++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: got cg_done pulses=%0d busy=%0b expected 1 and 0", name, done_cnt - d0, busy);
        end
    endtask

    task automatic test_mixed();
        int lv[6]  = '{2, 1, 3, 1, 5, 4};
        int eb[6]  = '{3, 2, 2, 2, 1, 1};
        int ec2[6] = '{0, 1, 1, 2, 2, 2};
        int ee[6]  = '{0, 0, 1, 0, 1, 1};
        int er[6]  = '{0, 0, 1, 0, 4, 3};
        run_seq("mixed", 6, lv, eb, ec2, ee, er);
    endtask

    task automatic test_ones();
        int lv[6]  = '{1, 1, 1, 1, 1, 1};
        int eb[6]  = '{3, 3, 3, 3, 1, 1};
        int ec2[6] = '{0, 0, 0, 0, 0, 0};
        int ee[6]  = '{0, 0, 0, 0, 1, 1};
        int er[6]  = '{0, 0, 0, 0, 0, 0};
        run_seq("ones", 6, lv, eb, ec2, ee, er);
    endtask

    task automatic test_latency();
        logic ok;
        int   waits;
        start_cg();
        send_in(16'd2, 1'b1, ok);
        wait_out(ok, waits);
        // Handshake edge H; out_valid visible after edge H+2, i.e. two negedges later.
        asserts++;
        if (!ok || waits !== 2) begin
            failures++;
            $display("FAIL latency: got waits=%0d valid=%0b expected 2 and 1", waits, ok);
        end
        $display("latency: waits=%0d", waits);
        accept_out();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic ok;
        int   waits;
        int   x0;
        int   d0;
        x0 = xfer_cnt;
        d0 = done_cnt;
        start_cg();
        send_in(16'd7, 1'b1, ok);
        wait_out(ok, waits);
        for (int i = 0; i < 4; i++) begin
            asserts++;
            if (out_valid !== 1'b1 || out_abs_level !== 16'd7 || out_base_level !== 8'd3
                || out_rem !== 16'd4 || out_escape !== 1'b1 || out_c1_idx !== 8'd0 || out_last !== 1'b1) begin
                failures++;
                $display("FAIL stall[%0d]: got v=%0b abs=%0d base=%0d rem=%0d esc=%0b c1=%0d expected 1,7,3,4,1,0",
                         i, out_valid, out_abs_level, out_base_level, out_rem, out_escape, out_c1_idx);
            end
            $display("stall cycle %0d: v=%0b abs=%0d base=%0d rem=%0d", i, out_valid, out_abs_level, out_base_level, out_rem);
            @(negedge clk);
        end
        accept_out();
        repeat (2) @(negedge clk);
        asserts++;
        if (xfer_cnt - x0 !== 1 || out_valid !== 1'b0 || done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL stall_xfer: got xfers=%0d valid=%0b done=%0d expected 1,0,1",
                     xfer_cnt - x0, out_valid, done_cnt - d0);
        end
    endtask

    task automatic test_zero_first();
        logic ok;
        int   waits;
        int   d0;
        int   seen;
        d0 = done_cnt;
        start_cg();
        send_in(16'd0, 1'b0, ok);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        asserts++;
        if (seen !== 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_noout: got valid cycles=%0d busy=%0b expected 0 and 1", seen, busy);
        end
        send_in(16'd3, 1'b1, ok);
        wait_out(ok, waits);
        asserts++;
        if (!ok || out_c1_idx !== 8'd0 || out_base_level !== 8'd3 || out_rem !== 16'd0 || out_escape !== 1'b1) begin
            failures++;
            $display("FAIL zero_then3: got v=%0b c1=%0d base=%0d rem=%0d esc=%0b expected 1,0,3,0,1",
                     ok, out_c1_idx, out_base_level, out_rem, out_escape);
        end
        $display("zero_first: c1=%0d base=%0d rem=%0d", out_c1_idx, out_base_level, out_rem);
        accept_out();
        repeat (2) @(negedge clk);
        asserts++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL zero_done: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_zero_last();
        logic ok;
        int   d0;
        d0 = done_cnt;
        start_cg();
        send_in(16'd0, 1'b1, ok);
        @(negedge clk);
        asserts++;
        if (!ok || done_cnt - d0 !== 1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_last: got done=%0d busy=%0b valid=%0b expected 1,0,0",
                     done_cnt - d0, busy, out_valid);
        end
        $display("zero_last: done=%0d busy=%0b", done_cnt - d0, busy);
    endtask

    task automatic test_reset_in_emit();
        logic ok;
        int   waits;
        start_cg();
        send_in(16'd2, 1'b0, ok);
        wait_out(ok, waits);
        accept_out();
        send_in(16'd5, 1'b0, ok);
        wait_out(ok, waits);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        asserts++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_abs_level !== 16'd0) begin
            failures++;
            $display("FAIL rst_emit: got valid=%0b busy=%0b abs=%0d expected 0,0,0", out_valid, busy, out_abs_level);
        end
        start_cg();
        send_in(16'd3, 1'b1, ok);
        wait_out(ok, waits);
        asserts++;
        if (!ok || out_c1_idx !== 8'd0 || out_c2_idx !== 8'd0 || out_base_level !== 8'd3) begin
            failures++;
            $display("FAIL rst_restart: got v=%0b c1=%0d c2=%0d base=%0d expected 1,0,0,3",
                     ok, out_c1_idx, out_c2_idx, out_base_level);
        end
        $display("reset_in_emit restart: c1=%0d c2=%0d base=%0d", out_c1_idx, out_c2_idx, out_base_level);
        accept_out();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cg_start_busy();
        logic ok;
        int   waits;
        start_cg();
        send_in(16'd2, 1'b0, ok);
        wait_out(ok, waits);
        accept_out();
        start_cg();                     // ignored: FSM is in ACCEPT
        send_in(16'd1, 1'b0, ok);
        wait_out(ok, waits);
        cg_start = 1'b1;                // ignored: FSM is in EMIT
        @(negedge clk);
        cg_start = 1'b0;
        asserts++;
        if (!ok || out_c1_idx !== 8'd1 || out_c2_idx !== 8'd1 || out_base_level !== 8'd2) begin
            failures++;
            $display("FAIL start_busy1: got v=%0b c1=%0d c2=%0d base=%0d expected 1,1,1,2",
                     ok, out_c1_idx, out_c2_idx, out_base_level);
        end
        accept_out();
        send_in(16'd3, 1'b1, ok);
        wait_out(ok, waits);
        asserts++;
        if (!ok || out_c1_idx !== 8'd2 || out_c2_idx !== 8'd1 || out_base_level !== 8'd2 || out_rem !== 16'd1) begin
            failures++;
            $display("FAIL start_busy2: got v=%0b c1=%0d c2=%0d base=%0d rem=%0d expected 1,2,1,2,1",
                     ok, out_c1_idx, out_c2_idx, out_base_level, out_rem);
        end
        $display("cg_start_busy: c1=%0d c2=%0d base=%0d rem=%0d", out_c1_idx, out_c2_idx, out_base_level, out_rem);
        accept_out();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        cg_start     = 1'b0;
        in_valid     = 1'b0;
        in_abs_level = 16'd0;
        in_last      = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_mixed();
        test_ones();
        test_latency();
        test_backpressure();
        test_zero_first();
        test_zero_last();
        test_reset_in_emit();
        test_cg_start_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
